// File: rtl/conv_geom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : conv_geom_pkg                                                    |
// | Shared widths and FSM encoding for the convolution geometry unit.          |
// | OUT = (IN + 2*PAD - K) / STRIDE + 1 is evaluated by a restoring divider    |
// | that retires one quotient bit per cycle over a DIM_WIDTH+2 bit numerator,  |
// | so a normal request takes CGU_DIV_ITERS cycles of iteration.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package conv_geom_pkg;

   localparam int CGU_DIM_WIDTH   = 16;
   localparam int CGU_COORD_WIDTH = 16;
   localparam int CGU_DATA_WIDTH  = 8;
   localparam int CGU_DIV_ITERS   = CGU_DIM_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR  = 2'd1,
      ST_RUN  = 2'd2
   } geom_state_e;

endpackage
`default_nettype wire

// File: rtl/conv_geom_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : conv_geom_div                                                    |
// | Unsigned sequential restoring divider, one quotient bit per cycle.         |
// | Ports   : clk, rst_n        clock, async active-low reset                  |
// |           start_i           load operands (always restarts)              |
// |           dividend_i        N_W-bit numerator                            |
// |           divisor_i         D_W-bit denominator                          |
// |           quotient_o        N_W-bit floor quotient                       |
// |           done_o            one-cycle pulse after the last iteration     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_geom_div #(
   parameter int N_W = 18,
   parameter int D_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [N_W-1:0] dividend_i,
   input  logic [D_W-1:0] divisor_i,
   output logic [N_W-1:0] quotient_o,
   output logic           done_o
);

   localparam int CNT_W = $clog2(N_W + 1);

   logic [N_W-1:0]   quot_q;
   logic [D_W-1:0]   rem_q;
   logic [D_W-1:0]   div_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;

   // quot_q starts as the dividend: its MSB shifts into the partial remainder
   // while the new quotient bit shifts in at the LSB.
   logic [D_W:0] w_trial;
   logic         w_ge;
   logic [D_W:0] w_diff;

   assign w_trial = {rem_q, quot_q[N_W-1]};
   assign w_ge    = (w_trial >= {1'b0, div_q});
   assign w_diff  = w_trial - {1'b0, div_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quot_q <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
            cnt_q  <= CNT_W'(N_W);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            // After a restoring step the remainder is below the divisor,
            // so it always fits back into D_W bits.
            rem_q  <= w_ge ? w_diff[D_W-1:0] : w_trial[D_W-1:0];
            quot_q <= {quot_q[N_W-2:0], w_ge};
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign quotient_o = quot_q;
   assign done_o     = done_q;

endmodule
`default_nettype wire

// File: rtl/conv_geometry_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : conv_geometry_unit                                               |
// | Output feature-map size calculator plus registered zero-padding check.    |
// | Ports   : clk, rst_n                    clock, async active-low reset      |
// |           dim_start_i                  request (ignored while busy)       |
// |           in_height_i .. padding_i     convolution parameters             |
// |           dim_busy_o/done_o/error_o    request status                     |
// |           out_height_o, out_width_o    computed output dimensions         |
// |           coord_i, max_coord_i         signed coordinate, exclusive bound |
// |           memory_data_i                pixel from the input buffer        |
// |           valid_coord_o, input_data_o  registered padding result          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_geometry_unit
   import conv_geom_pkg::*;
#(
   parameter int DIM_WIDTH   = CGU_DIM_WIDTH,
   parameter int COORD_WIDTH = CGU_COORD_WIDTH,
   parameter int DATA_WIDTH  = CGU_DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   dim_start_i,
   input  logic [DIM_WIDTH-1:0]   in_height_i,
   input  logic [DIM_WIDTH-1:0]   in_width_i,
   input  logic [DIM_WIDTH-1:0]   kernel_size_i,
   input  logic [DIM_WIDTH-1:0]   stride_i,
   input  logic [DIM_WIDTH-1:0]   padding_i,
   output logic                   dim_busy_o,
   output logic                   dim_done_o,
   output logic                   dim_error_o,
   output logic [DIM_WIDTH-1:0]   out_height_o,
   output logic [DIM_WIDTH-1:0]   out_width_o,
   input  logic [COORD_WIDTH-1:0] coord_i,
   input  logic [COORD_WIDTH-1:0] max_coord_i,
   input  logic [DATA_WIDTH-1:0]  memory_data_i,
   output logic                   valid_coord_o,
   output logic [DATA_WIDTH-1:0]  input_data_o
);

   localparam int NUM_W = DIM_WIDTH + 2;

   geom_state_e state_q, state_d;

   logic                 w_accept;
   logic                 w_bad_req;
   logic                 w_div_start;
   logic                 w_finish_err;
   logic                 w_finish_run;
   logic [NUM_W-1:0]     w_sum_h, w_sum_w, w_k_ext, w_num_h, w_num_w;
   logic [NUM_W-1:0]     w_quot_h, w_quot_w;
   logic                 w_done_h, w_done_w;
   logic                 w_sat_h, w_sat_w;

   logic                 dim_done_q, dim_error_q;
   logic [DIM_WIDTH-1:0] out_height_q, out_width_q;
   logic                 valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   // IN + 2*PAD fits in DIM_WIDTH+2 bits without wrap; the subtraction is
   // only consumed when K does not exceed it, so the numerator is never negative.
   assign w_k_ext = NUM_W'(kernel_size_i);
   assign w_sum_h = NUM_W'(in_height_i) + {1'b0, padding_i, 1'b0};
   assign w_sum_w = NUM_W'(in_width_i)  + {1'b0, padding_i, 1'b0};
   assign w_num_h = w_sum_h - w_k_ext;
   assign w_num_w = w_sum_w - w_k_ext;

   assign w_bad_req = (stride_i == '0) || (kernel_size_i == '0) ||
                      (w_k_ext > w_sum_h) || (w_k_ext > w_sum_w);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (dim_start_i) state_d = w_bad_req ? ST_ERR : ST_RUN;
         ST_ERR:  state_d = ST_IDLE;
         ST_RUN:  if (w_done_h) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      dim_busy_o   = (state_q != ST_IDLE);
      w_accept     = (state_q == ST_IDLE) && dim_start_i;
      w_div_start  = w_accept && !w_bad_req;
      w_finish_err = (state_q == ST_ERR);
      w_finish_run = (state_q == ST_RUN) && w_done_h;
   end

   conv_geom_div #(.N_W(NUM_W), .D_W(DIM_WIDTH)) u_div_h (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (w_div_start),
      .dividend_i (w_num_h),
      .divisor_i  (stride_i),
      .quotient_o (w_quot_h),
      .done_o     (w_done_h)
   );

   conv_geom_div #(.N_W(NUM_W), .D_W(DIM_WIDTH)) u_div_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (w_div_start),
      .dividend_i (w_num_w),
      .divisor_i  (stride_i),
      .quotient_o (w_quot_w),
      .done_o     (w_done_w)
   );

   // quotient+1 overflows DIM_WIDTH once the quotient reaches all-ones.
   assign w_sat_h = (|w_quot_h[NUM_W-1:DIM_WIDTH]) || (&w_quot_h[DIM_WIDTH-1:0]);
   assign w_sat_w = (|w_quot_w[NUM_W-1:DIM_WIDTH]) || (&w_quot_w[DIM_WIDTH-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dim_done_q   <= 1'b0;
         dim_error_q  <= 1'b0;
         out_height_q <= '0;
         out_width_q  <= '0;
      end else begin
         dim_done_q <= 1'b0;
         if (w_finish_err) begin
            dim_done_q   <= 1'b1;
            dim_error_q  <= 1'b1;
            out_height_q <= '0;
            out_width_q  <= '0;
         end else if (w_finish_run) begin
            dim_done_q   <= 1'b1;
            dim_error_q  <= w_sat_h || w_sat_w;
            out_height_q <= w_sat_h ? '1 : (w_quot_h[DIM_WIDTH-1:0] + DIM_WIDTH'(1));
            out_width_q  <= w_sat_w ? '1 : (w_quot_w[DIM_WIDTH-1:0] + DIM_WIDTH'(1));
         end
      end
   end

   // Padding check: sign-extend coord and zero-extend max_coord by one bit so
   // a full-range unsigned bound compares correctly against a signed coordinate.
   logic w_coord_ok;
   assign w_coord_ok = !coord_i[COORD_WIDTH-1] &&
                       ($signed({coord_i[COORD_WIDTH-1], coord_i}) < $signed({1'b0, max_coord_i}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= w_coord_ok;
         data_q  <= w_coord_ok ? memory_data_i : '0;
      end
   end

   assign dim_done_o    = dim_done_q;
   assign dim_error_o   = dim_error_q;
   assign out_height_o  = out_height_q;
   assign out_width_o   = out_width_q;
   assign valid_coord_o = valid_q;
   assign input_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_geometry_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_conv_geometry_unit                                            |
// | Self-checking bench for conv_geometry_unit with a behavioural model of    |
// | the output-size formula and of the padding rule.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_conv_geometry_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dim_start_i = 1'b0;
   logic [15:0] in_height_i = '0, in_width_i = '0, kernel_size_i = '0;
   logic [15:0] stride_i = '0, padding_i = '0;
   logic        dim_busy_o, dim_done_o, dim_error_o;
   logic [15:0] out_height_o, out_width_o;
   logic [15:0] coord_i = '0, max_coord_i = '0;
   logic [7:0]  memory_data_i = '0;
   logic        valid_coord_o;
   logic [7:0]  input_data_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_geometry_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dim_start_i   (dim_start_i),
      .in_height_i   (in_height_i),
      .in_width_i    (in_width_i),
      .kernel_size_i (kernel_size_i),
      .stride_i      (stride_i),
      .padding_i     (padding_i),
      .dim_busy_o    (dim_busy_o),
      .dim_done_o    (dim_done_o),
      .dim_error_o   (dim_error_o),
      .out_height_o  (out_height_o),
      .out_width_o   (out_width_o),
      .coord_i       (coord_i),
      .max_coord_i   (max_coord_i),
      .memory_data_i (memory_data_i),
      .valid_coord_o (valid_coord_o),
      .input_data_o  (input_data_o)
   );

   // ---------------- reference model ----------------
   task automatic model_dim(input int h, w, k, s, p,
                            output logic [15:0] oh, output logic [15:0] ow,
                            output logic err, output int lat);
      longint sh, sw, qh, qw;
      sh = h + 2 * p;
      sw = w + 2 * p;
      if (s == 0 || k == 0 || k > sh || k > sw) begin
         oh = 0; ow = 0; err = 1; lat = 1;
      end else begin
         qh = (sh - k) / s + 1;
         qw = (sw - k) / s + 1;
         err = (qh > 65535) || (qw > 65535);
         oh = (qh > 65535) ? 16'hFFFF : 16'(qh);
         ow = (qw > 65535) ? 16'hFFFF : 16'(qw);
         lat = 19;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive_params(input int h, w, k, s, p);
      in_height_i   = 16'(h);
      in_width_i    = 16'(w);
      kernel_size_i = 16'(k);
      stride_i      = 16'(s);
      padding_i     = 16'(p);
   endtask

   // Counts edges after the accepting edge until dim_done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (dim_done_o) begin lat = i; break; end
      end
   endtask

   task automatic run_dim(input int h, w, k, s, p, output int lat);
      @(negedge clk);
      drive_params(h, w, k, s, p);
      dim_start_i = 1'b1;
      @(posedge clk); #1;
      dim_start_i = 1'b0;
      wait_done(lat);
   endtask

   // Runs one request and compares everything against the model.
   task automatic check_dim(input string name, input int h, w, k, s, p);
      logic [15:0] eh, ew; logic eerr; int elat, lat;
      model_dim(h, w, k, s, p, eh, ew, eerr, elat);
      run_dim(h, w, k, s, p, lat);
      checks++;
      if (lat !== elat || out_height_o !== eh || out_width_o !== ew || dim_error_o !== eerr) begin
         errors++;
         $display("FAIL %s: got lat=%0d h=%0d w=%0d err=%0b, need lat=%0d h=%0d w=%0d err=%0b",
                  name, lat, out_height_o, out_width_o, dim_error_o, elat, eh, ew, eerr);
      end
      @(posedge clk); #1;
      checks++;
      if (dim_done_o !== 1'b0 || dim_busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse: done=%0b busy=%0b, need 0 0", name, dim_done_o, dim_busy_o);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2;
      checks++;
      if ({dim_busy_o, dim_done_o, dim_error_o, out_height_o, out_width_o, valid_coord_o, input_data_o} !== '0) begin
         errors++;
         $display("FAIL reset: busy=%0b done=%0b err=%0b h=%0d w=%0d v=%0b d=%0h, need all 0",
                  dim_busy_o, dim_done_o, dim_error_o, out_height_o, out_width_o, valid_coord_o, input_data_o);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_dim_directed();
      check_dim("dim_5x5_k3_s1_p1", 5, 5, 3, 1, 1);
      check_dim("dim_7x6_k3_s2",    7, 6, 3, 2, 0);
      check_dim("dim_k_too_big",    2, 2, 5, 1, 0);
      check_dim("dim_stride0",      7, 6, 3, 0, 0);
      check_dim("dim_kernel0",      7, 6, 0, 1, 0);
      check_dim("dim_k_eq_extent",  4, 9, 6, 3, 1);
      check_dim("dim_max_no_sat",   65535, 65535, 1, 1, 0);
      check_dim("dim_saturate",     65535, 100, 1, 1, 1);
      check_dim("dim_big_stride",   65535, 65535, 3, 65535, 65535);
   endtask

   task automatic test_dim_random();
      for (int i = 0; i < 12; i++) begin
         int h, w, k, s, p;
         h = $urandom_range(1, 400);
         w = $urandom_range(1, 400);
         k = $urandom_range(0, 9);
         s = $urandom_range(0, 5);
         p = $urandom_range(0, 4);
         if (i % 4 == 3) h = $urandom_range(0, 3);
         check_dim($sformatf("dim_rand%0d", i), h, w, k, s, p);
      end
   endtask

   task automatic test_padding();
      int cs [5] = '{-1, 0, 4, 5, 6};
      int n;
      logic ev; logic [7:0] ed;
      // directed, then extremes, then random; one new vector every cycle
      n = 5 + 3 + 30;
      for (int i = 0; i < n; i++) begin
         int c, m, d;
         if (i < 5)       begin c = cs[i]; m = 5; d = 8'hAB; end
         else if (i == 5) begin c = -32768; m = 65535; d = 8'h5C; end
         else if (i == 6) begin c = 32767;  m = 65535; d = 8'h3D; end
         else if (i == 7) begin c = 0;      m = 0;     d = 8'hFF; end
         else begin
            c = int'($signed(16'($urandom_range(0, 65535))));
            if (i % 2 == 0) c = int'($urandom_range(0, 20)) - 4;
            m = (i % 3 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 16);
            d = $urandom_range(0, 255);
         end
         @(negedge clk);
         coord_i = 16'(c); max_coord_i = 16'(m); memory_data_i = 8'(d);
         ev = (c >= 0) && (c < m);
         ed = ev ? 8'(d) : 8'h00;
         @(posedge clk); #1;
         checks++;
         if (valid_coord_o !== ev || input_data_o !== ed) begin
            errors++;
            $display("FAIL pad%0d coord=%0d max=%0d: got (%0b,%h) need (%0b,%h)",
                     i, c, m, valid_coord_o, input_data_o, ev, ed);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [15:0] eh, ew; logic eerr; int elat, lat;
      model_dim(9, 11, 3, 2, 1, eh, ew, eerr, elat);
      @(negedge clk);
      drive_params(9, 11, 3, 2, 1);
      dim_start_i = 1'b1;
      @(posedge clk); #1;
      dim_start_i = 1'b0;
      drive_params(100, 100, 1, 1, 0);
      repeat (5) @(posedge clk);
      @(negedge clk); dim_start_i = 1'b1;
      @(negedge clk); dim_start_i = 1'b0;
      // 6 edges consumed since acceptance; remaining wait counts from there
      wait_done(lat);
      if (lat > 0) lat = lat + 6;
      checks++;
      if (lat !== elat || out_height_o !== eh || out_width_o !== ew || dim_error_o !== eerr) begin
         errors++;
         $display("FAIL busy_ignore: got lat=%0d h=%0d w=%0d err=%0b, need lat=%0d h=%0d w=%0d err=%0b",
                  lat, out_height_o, out_width_o, dim_error_o, elat, eh, ew, eerr);
      end
      // the restart attempt must not produce a second completion
      wait_done(lat);
      checks++;
      if (lat !== -1) begin
         errors++;
         $display("FAIL busy_ignore_extra: got extra done at %0d, need none", lat);
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      @(negedge clk);
      drive_params(20, 20, 3, 1, 0);
      coord_i = 16'd1; max_coord_i = 16'd4; memory_data_i = 8'h77;
      dim_start_i = 1'b1;
      @(posedge clk); #1;
      dim_start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dim_busy_o !== 1'b1 || valid_coord_o !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy: busy=%0b valid=%0b, need 1 1", dim_busy_o, valid_coord_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dim_busy_o, dim_done_o, dim_error_o, out_height_o, out_width_o, valid_coord_o, input_data_o} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: busy=%0b done=%0b err=%0b h=%0d w=%0d v=%0b d=%0h, need all 0",
                  dim_busy_o, dim_done_o, dim_error_o, out_height_o, out_width_o, valid_coord_o, input_data_o);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      wait_done(lat);
      checks++;
      if (lat !== -1) begin
         errors++;
         $display("FAIL midrun_no_done: got done at %0d, need none", lat);
      end
      check_dim("after_reset", 13, 8, 2, 3, 2);
   endtask

   task automatic test_back_to_back();
      logic [15:0] eh, ew; logic eerr; int elat, lat;
      run_dim(10, 12, 3, 1, 0, lat);
      checks++;
      if (lat !== 19 || out_height_o !== 16'd8 || out_width_o !== 16'd10) begin
         errors++;
         $display("FAIL b2b_first: got lat=%0d h=%0d w=%0d, need 19 8 10", lat, out_height_o, out_width_o);
      end
      model_dim(31, 17, 5, 3, 2, eh, ew, eerr, elat);
      // still inside the dim_done cycle
      drive_params(31, 17, 5, 3, 2);
      dim_start_i = 1'b1;
      @(posedge clk); #1;
      dim_start_i = 1'b0;
      checks++;
      if (dim_busy_o !== 1'b1 || out_height_o !== 16'd8) begin
         errors++;
         $display("FAIL b2b_accept: busy=%0b h=%0d, need 1 8", dim_busy_o, out_height_o);
      end
      wait_done(lat);
      checks++;
      if (lat !== elat || out_height_o !== eh || out_width_o !== ew || dim_error_o !== eerr) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d h=%0d w=%0d err=%0b, need lat=%0d h=%0d w=%0d err=%0b",
                  lat, out_height_o, out_width_o, dim_error_o, elat, eh, ew, eerr);
      end
   endtask

   initial begin
      test_reset();
      test_dim_directed();
      test_padding();
      test_busy_ignore();
      test_reset_midrun();
      test_back_to_back();
      test_dim_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
